instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the fetch program counter and issues single-outstanding requests to instruction memory. Returned words are buffered with their PC in a small prefetch FIFO, and the head entry is presented to IF/ID as instruction plus PC. Taken-branch redirects arriving from EX/MEM flush the buffer, discard any in-flight response and restart fetch at the target.

---
 rtl/instr_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: fetch PC, single-outstanding imem requests, prefetch FIFO, redirect flush
// Optional feature macro: IFU_BYPASS_EN (response shown combinationally to IF/ID when the FIFO is empty)
module instr_fetch_unit #(
  parameter int              PC_W       = 64,
  parameter int              INST_W     = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req_o,
  output logic [PC_W-1:0]             imem_addr_o,
  input  logic                        imem_ack_i,
  input  logic [INST_W-1:0]           imem_rdata_i,
  input  logic                        redirect_i,
  input  logic [PC_W-1:0]             redirect_pc_i,
  input  logic                        stall_i,
  output logic                        inst_valid_o,
  output logic [INST_W-1:0]           inst_o,
  output logic [PC_W-1:0]             pc_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            LW      = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [INST_W-1:0] inst_mem_q [FIFO_DEPTH];
  logic [PC_W-1:0]   pc_mem_q   [FIFO_DEPTH];

  logic              fifo_empty;
  logic              accept;
  logic              bypass_hit;
  logic              head_valid;
  logic              pop_fifo;
  logic              push;
  logic [LW-1:0]     level_pp;
  logic              issue;

  // Target alignment drops the two low bits of the redirect address.
  logic              unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // FIFO push/pop qualification; a response is accepted only in WAIT without a redirect
  always_comb begin
    fifo_empty = (level_q == '0);
    accept     = (state_q == S_WAIT) && imem_ack_i && !redirect_i;
    bypass_hit = 1'b0;
`ifdef IFU_BYPASS_EN
    bypass_hit = accept && fifo_empty;
`endif
    head_valid = !fifo_empty || bypass_hit;
    pop_fifo   = !fifo_empty && !stall_i && !redirect_i;
    // A bypassed word consumed in its ack cycle never touches storage.
    push       = accept && !(bypass_hit && !stall_i);
    level_pp   = level_q + LW'(push) - LW'(pop_fifo);
  end

  // Request FSM: next state and request issue decision
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!redirect_i && (level_q < DEPTH_L)) begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          // Same-cycle ack is simply dropped; otherwise wait out the stale response.
          state_d = imem_ack_i ? S_IDLE : S_DISCARD;
        end else if (imem_ack_i) begin
          if (level_pp < DEPTH_L) begin
            issue   = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        if (imem_ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch PC, request tag PC, FIFO pointers and level next-state
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[PC_W-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      level_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + PC_W'(4);
        req_pc_d   = fetch_pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_fifo) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      level_d = level_pp;
    end
  end

  // State registers and FIFO storage with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      if (push) begin
        inst_mem_q[wr_ptr_q] <= imem_rdata_i;
        pc_mem_q[wr_ptr_q]   <= req_pc_q;
      end
    end
  end

  // Outputs; reset forces the idle values even before the registers settle
  always_comb begin
    imem_req_o   = issue && !rst;
    imem_addr_o  = rst ? RESET_PC : fetch_pc_q;
    inst_valid_o = head_valid && !rst;
    fifo_level_o = rst ? '0 : level_q;
    inst_o       = '0;
    pc_o         = '0;
    if (!rst) begin
      if (bypass_hit) begin
        inst_o = imem_rdata_i;
        pc_o   = req_pc_q;
      end else begin
        inst_o = inst_mem_q[rd_ptr_q];
        pc_o   = pc_mem_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit with queue-based reference model
module tb_instr_fetch_unit;

  localparam int          PC_W   = 64;
  localparam int          INST_W = 32;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] RPC    = 64'h0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req_o;
  logic [PC_W-1:0]   imem_addr_o;
  logic              imem_ack_i = 1'b0;
  logic [INST_W-1:0] imem_rdata_i = '0;
  logic              redirect_i = 1'b0;
  logic [PC_W-1:0]   redirect_pc_i = '0;
  logic              stall_i = 1'b0;
  logic              inst_valid_o;
  logic [INST_W-1:0] inst_o;
  logic [PC_W-1:0]   pc_o;
  logic [2:0]        fifo_level_o;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .PC_W(PC_W), .INST_W(INST_W), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o),
    .fifo_level_o(fifo_level_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // memory environment
  int          fixed_lat = 1;
  logic        keep_pending = 1'b0;
  logic        mem_pending = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;

  // reference model: queue of {pc, inst}, outstanding request bookkeeping
  logic [95:0] mq[$];
  logic        m_out = 1'b0;
  logic        m_doom = 1'b0;
  logic [63:0] m_npc = RPC;
  logic [63:0] m_rpc = RPC;

  // observed and expected per-cycle values
  logic        obs_req, obs_valid, obs_cons;
  logic [63:0] obs_addr, obs_pc;
  logic [31:0] obs_inst;
  logic [2:0]  obs_level;
  logic        exp_req, exp_valid;
  logic [63:0] exp_addr, exp_pc;
  logic [31:0] exp_inst;
  logic [2:0]  exp_level;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] * 32'd3 + 32'h13;
  endfunction

  task automatic run_cycle(input logic r, input logic s, input logic rd, input logic [63:0] rpc);
    logic ack_this, accepted, byp, consume, push, pop_q;
    rst = r;
    stall_i = s;
    redirect_i = rd;
    redirect_pc_i = rpc;
    imem_ack_i = 1'b0;
    imem_rdata_i = $urandom;
    if (mem_pending) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_ack_i = 1'b1;
        imem_rdata_i = word_of(mem_addr);
        mem_pending = 1'b0;
      end
    end
    @(negedge clk);
    obs_req = imem_req_o;
    obs_addr = imem_addr_o;
    obs_valid = inst_valid_o;
    obs_inst = inst_o;
    obs_pc = pc_o;
    obs_level = fifo_level_o;
    obs_cons = inst_valid_o && !s && !rd && !r;
    if (r) begin
      exp_req = 1'b0; exp_addr = RPC; exp_valid = 1'b0;
      exp_inst = '0; exp_pc = '0; exp_level = '0;
      mq.delete();
      m_out = 1'b0; m_doom = 1'b0; m_npc = RPC;
    end else begin
      ack_this = imem_ack_i && m_out;
      accepted = ack_this && !m_doom && !rd;
      byp = 1'b0;
`ifdef IFU_BYPASS_EN
      byp = accepted && (mq.size() == 0);
`endif
      exp_valid = (mq.size() != 0) || byp;
      exp_pc = '0;
      exp_inst = '0;
      if (mq.size() != 0) begin
        exp_pc = mq[0][95:32];
        exp_inst = mq[0][31:0];
      end else if (byp) begin
        exp_pc = m_rpc;
        exp_inst = word_of(m_rpc);
      end
      consume = exp_valid && !s && !rd;
      push = accepted && !(byp && consume);
      pop_q = consume && (mq.size() != 0);
      exp_level = 3'(mq.size());
      exp_addr = m_npc;
      if (!m_out) exp_req = !rd && (mq.size() < DEPTH);
      else exp_req = accepted && ((mq.size() + int'(push) - int'(pop_q)) < DEPTH);
      if (rd) begin
        mq.delete();
        m_npc = {rpc[63:2], 2'b00};
        if (ack_this) m_out = 1'b0;
        else if (m_out) m_doom = 1'b1;
      end else begin
        if (pop_q) void'(mq.pop_front());
        if (push) mq.push_back({m_rpc, word_of(m_rpc)});
        if (ack_this) m_out = 1'b0;
        if (exp_req) begin
          m_out = 1'b1; m_doom = 1'b0; m_rpc = m_npc; m_npc = m_npc + 64'd4;
        end
      end
    end
    if (r && !keep_pending) mem_pending = 1'b0;
    if (!r && obs_req) begin
      mem_pending = 1'b1;
      mem_cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
      mem_addr = obs_addr;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fixed_lat = 1;
    run_cycle(1, 0, 0, '0);
    run_cycle(1, 0, 0, '0);
    checks++; if (obs_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", obs_req); end
    checks++; if (obs_addr !== RPC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", obs_addr, RPC); end
    checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", obs_valid); end
    checks++; if (obs_inst !== 32'h0 || obs_pc !== 64'h0) begin failures++; $display("FAIL reset_head got=%h/%h exp=0/0", obs_inst, obs_pc); end
    checks++; if (obs_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", obs_level); end
  endtask

  task automatic test_stream();
    int n_cons = 0;
    int n_exp;
    fixed_lat = 1;
    run_cycle(1, 0, 0, '0);
    for (int i = 0; i < 16; i++) begin
      run_cycle(0, 0, 0, '0);
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== 64'(4 * i)) begin
        failures++; $display("FAIL stream_req i=%0d got=%0b@%h exp=1@%h", i, obs_req, obs_addr, 64'(4 * i));
      end
      if (obs_cons) begin
        checks++;
        if (obs_pc !== 64'(4 * n_cons) || obs_inst !== word_of(64'(4 * n_cons))) begin
          failures++; $display("FAIL stream_head n=%0d got=%h/%h exp=%h/%h", n_cons, obs_pc, obs_inst, 64'(4 * n_cons), word_of(64'(4 * n_cons)));
        end
        n_cons++;
      end
    end
`ifdef IFU_BYPASS_EN
    n_exp = 15;
`else
    n_exp = 14;
`endif
    checks++; if (n_cons != n_exp) begin failures++; $display("FAIL stream_rate got=%0d exp=%0d", n_cons, n_exp); end
  endtask

  task automatic test_stall();
    int n_cons = 0;
    logic seen_req = 1'b0;
    fixed_lat = 1;
    run_cycle(1, 0, 0, '0);
    for (int i = 0; i < 10; i++) begin
      run_cycle(0, 1, 0, '0);
      checks++;
      if (obs_req !== (i < 4) || (i < 4 && obs_addr !== 64'(4 * i))) begin
        failures++; $display("FAIL stall_req i=%0d got=%0b@%h exp=%0b", i, obs_req, obs_addr, (i < 4));
      end
      if (obs_valid) begin
        checks++;
        if (obs_pc !== 64'h0 || obs_inst !== word_of(64'h0)) begin
          failures++; $display("FAIL stall_hold i=%0d got=%h/%h exp=0/%h", i, obs_pc, obs_inst, word_of(64'h0));
        end
      end
    end
    checks++; if (obs_level !== 3'd4) begin failures++; $display("FAIL stall_level got=%0d exp=4", obs_level); end
    for (int i = 0; i < 40 && n_cons < 8; i++) begin
      run_cycle(0, 0, 0, '0);
      if (obs_req && !seen_req) begin
        seen_req = 1'b1;
        checks++; if (obs_addr !== 64'h10) begin failures++; $display("FAIL stall_resume got=%h exp=10", obs_addr); end
      end
      if (obs_cons) begin
        checks++;
        if (obs_pc !== 64'(4 * n_cons)) begin failures++; $display("FAIL stall_drain n=%0d got=%h exp=%h", n_cons, obs_pc, 64'(4 * n_cons)); end
        n_cons++;
      end
    end
    checks++; if (n_cons != 8 || !seen_req) begin failures++; $display("FAIL stall_timeout got=%0d exp=8", n_cons); end
  endtask

  task automatic test_redirect_wait();
    logic found = 1'b0;
    fixed_lat = 3;
    run_cycle(1, 0, 0, '0);
    run_cycle(0, 0, 0, '0);
    run_cycle(0, 0, 1, 64'h103);
    checks++; if (obs_req !== 1'b0) begin failures++; $display("FAIL rdw_req_r got=%0b exp=0", obs_req); end
    run_cycle(0, 0, 0, '0);
    checks++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin failures++; $display("FAIL rdw_r1 got=%0b/%0b exp=0/0", obs_req, obs_valid); end
    run_cycle(0, 0, 0, '0);
    checks++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin failures++; $display("FAIL rdw_discard got=%0b/%0b exp=0/0", obs_req, obs_valid); end
    run_cycle(0, 0, 0, '0);
    checks++; if (obs_req !== 1'b1 || obs_addr !== 64'h100) begin failures++; $display("FAIL rdw_newreq got=%0b@%h exp=1@100", obs_req, obs_addr); end
    checks++; if (obs_level !== 3'd0) begin failures++; $display("FAIL rdw_level got=%0d exp=0", obs_level); end
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle(0, 0, 0, '0);
      if (obs_valid) begin
        found = 1'b1;
        checks++;
        if (obs_pc !== 64'h100 || obs_inst !== word_of(64'h100)) begin
          failures++; $display("FAIL rdw_first got=%h/%h exp=100/%h", obs_pc, obs_inst, word_of(64'h100));
        end
      end
    end
    checks++; if (!found) begin failures++; $display("FAIL rdw_timeout got=none exp=valid"); end
  endtask

  task automatic test_redirect_ack_same();
    fixed_lat = 2;
    run_cycle(1, 0, 0, '0);
    run_cycle(0, 0, 0, '0);
    run_cycle(0, 0, 0, '0);
    run_cycle(0, 0, 1, 64'h200);
    checks++; if (obs_req !== 1'b0) begin failures++; $display("FAIL rda_req_r got=%0b exp=0", obs_req); end
    run_cycle(0, 0, 0, '0);
    checks++; if (obs_valid !== 1'b0 || obs_level !== 3'd0) begin failures++; $display("FAIL rda_empty got=%0b/%0d exp=0/0", obs_valid, obs_level); end
    checks++; if (obs_req !== 1'b1 || obs_addr !== 64'h200) begin failures++; $display("FAIL rda_newreq got=%0b@%h exp=1@200", obs_req, obs_addr); end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    fixed_lat = 2;
    run_cycle(1, 0, 0, '0);
    run_cycle(0, 0, 0, '0);
    keep_pending = 1'b1;
    run_cycle(1, 0, 0, '0);
    keep_pending = 1'b0;
    checks++; if (obs_req !== 1'b0 || obs_valid !== 1'b0 || obs_level !== 3'd0) begin failures++; $display("FAIL rmid_rst got=%0b/%0b/%0d exp=0/0/0", obs_req, obs_valid, obs_level); end
    checks++; if (obs_addr !== RPC || obs_inst !== 32'h0 || obs_pc !== 64'h0) begin failures++; $display("FAIL rmid_rst_vals got=%h/%h/%h exp=0", obs_addr, obs_inst, obs_pc); end
    run_cycle(0, 0, 0, '0);
    checks++; if (obs_req !== 1'b1 || obs_addr !== RPC || obs_valid !== 1'b0) begin failures++; $display("FAIL rmid_late got=%0b@%h v=%0b exp=1@%h v=0", obs_req, obs_addr, obs_valid, RPC); end
    run_cycle(0, 0, 0, '0);
    checks++; if (obs_level !== 3'd0 || obs_valid !== 1'b0 || obs_req !== 1'b0) begin failures++; $display("FAIL rmid_ignored got=%0d/%0b/%0b exp=0/0/0", obs_level, obs_valid, obs_req); end
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle(0, 0, 0, '0);
      if (obs_valid) begin
        found = 1'b1;
        checks++; if (obs_pc !== RPC || obs_inst !== word_of(RPC)) begin failures++; $display("FAIL rmid_first got=%h/%h exp=%h", obs_pc, obs_inst, RPC); end
      end
    end
    checks++; if (!found) begin failures++; $display("FAIL rmid_timeout got=none exp=valid"); end
  endtask

  task automatic test_first_word();
    fixed_lat = 1;
    run_cycle(1, 0, 0, '0);
    run_cycle(0, 0, 0, '0);
    run_cycle(0, 0, 0, '0);
`ifdef IFU_BYPASS_EN
    checks++; if (obs_valid !== 1'b1 || obs_inst !== 32'h13) begin failures++; $display("FAIL fw_ack got=%0b/%h exp=1/13", obs_valid, obs_inst); end
    checks++; if (obs_level !== 3'd0) begin failures++; $display("FAIL fw_ack_level got=%0d exp=0", obs_level); end
`else
    checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL fw_ack got=%0b exp=0", obs_valid); end
    checks++; if (obs_level !== 3'd0) begin failures++; $display("FAIL fw_ack_level got=%0d exp=0", obs_level); end
`endif
    run_cycle(0, 0, 0, '0);
`ifdef IFU_BYPASS_EN
    checks++; if (obs_valid !== 1'b1 || obs_pc !== 64'h4 || obs_inst !== word_of(64'h4)) begin failures++; $display("FAIL fw_next got=%0b/%h/%h exp=1/4/%h", obs_valid, obs_pc, obs_inst, word_of(64'h4)); end
    checks++; if (obs_level !== 3'd0) begin failures++; $display("FAIL fw_next_level got=%0d exp=0", obs_level); end
`else
    checks++; if (obs_valid !== 1'b1 || obs_pc !== 64'h0 || obs_inst !== 32'h13) begin failures++; $display("FAIL fw_next got=%0b/%h/%h exp=1/0/13", obs_valid, obs_pc, obs_inst); end
    checks++; if (obs_level !== 3'd1) begin failures++; $display("FAIL fw_next_level got=%0d exp=1", obs_level); end
`endif
  endtask

  task automatic test_random();
    logic r, s, rd;
    logic [63:0] rpc;
    fixed_lat = 0;
    run_cycle(1, 0, 0, '0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 9) < 3);
      rd = !r && ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else rpc = {32'h0, $urandom};
      run_cycle(r, s, rd, rpc);
      checks++; if (obs_req !== exp_req) begin failures++; $display("FAIL rand_req cyc=%0d got=%0b exp=%0b", cyc, obs_req, exp_req); end
      checks++; if (obs_addr !== exp_addr) begin failures++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_addr); end
      checks++; if (obs_valid !== exp_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, obs_valid, exp_valid); end
      checks++; if (obs_level !== exp_level) begin failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", cyc, obs_level, exp_level); end
      if (exp_valid || r) begin
        checks++;
        if (obs_pc !== exp_pc || obs_inst !== exp_inst) begin
          failures++; $display("FAIL rand_head cyc=%0d got=%h/%h exp=%h/%h", cyc, obs_pc, obs_inst, exp_pc, exp_inst);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_ack_same();
    test_reset_mid();
    test_first_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
